// File: rtl/sata_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : sata_cmd_sched
// Description : Round-robin scheduler that shares the single command port of
//               the SATA command DMA controller among NUM_REQ host requesters.
//               One request is accepted at a time, driven onto cmd_tdata until
//               cmd_ack, then the scheduler waits for dma_done (or a timeout)
//               and returns a one-hot response pulse with an error flag.
//
// Ports       : clk        - clock
//               rst_n      - synchronous active-low reset
//               req_valid  - per-requester request valid
//               req_ready  - one-hot accept pulse (same cycle req_cmd sampled)
//               req_cmd    - per-requester {RW,len[22:0],addr[47:0]}
//               cmd_tdata  - {vld,RW,len[22:0],addr[47:0]} to DMA controller
//               cmd_ack    - DMA controller accepted the command
//               dma_done   - current command finished
//               dma_err    - qualifies dma_done, 1 = command failed
//               rsp_valid  - one-hot completion pulse to the owner
//               rsp_err    - error flag, valid with rsp_valid
//               busy       - high whenever the scheduler is not idle
//               grant_id   - index of the current/last owner
//
// Revision    : 1.0 - initial release
// ============================================================================
module sata_cmd_sched #(
    parameter int              NUM_REQ = 4,
    parameter int              TO_W    = 24,
    parameter logic [TO_W-1:0] TO_MAX  = TO_W'(24'hFF_FFFF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*72-1:0]   req_cmd,
    output logic [72:0]             cmd_tdata,
    input  logic                    cmd_ack,
    input  logic                    dma_done,
    input  logic                    dma_err,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [2:0]         r_rr_ptr;
    logic [2:0]         r_grant;
    logic [71:0]        r_cmd;
    logic               r_vld;
    logic [TO_W-1:0]    r_to_cnt;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_err;

    logic [7:0]         w_valid8;
    logic [3:0]         w_sum;
    logic [2:0]         w_win;
    logic               w_found;
    logic [71:0]        w_sel_cmd;
    logic               w_accept;
    logic [2:0]         w_next_ptr;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [NUM_REQ-1:0] w_grant_onehot;
    logic               w_to_hit;

    // Zero-extended copy so a 3-bit index is always in range.
    assign w_valid8 = 8'(req_valid);

    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_sum   = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + 4'(k);
            if (w_sum >= 4'(NUM_REQ)) begin
                w_sum = w_sum - 4'(NUM_REQ);
            end
            if (!w_found && w_valid8[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[2:0];
            end
        end
    end

    always_comb begin
        w_sel_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == 3'(i)) begin
                w_sel_cmd = req_cmd[72*i +: 72];
            end
        end
    end

    // A handshake during a reset cycle would be lost, so ready is gated.
    assign w_accept       = rst_n && (r_state == c_IDLE) && w_found;
    assign w_win_onehot   = NUM_REQ'(8'b1 << w_win);
    assign w_grant_onehot = NUM_REQ'(8'b1 << r_grant);
    assign w_next_ptr     = (w_win == 3'(NUM_REQ - 1)) ? 3'd0 : w_win + 3'd1;

    // Counter reads TO_MAX-1 on the TO_MAX-th WAIT cycle; the >= also covers
    // the saturated value so a timeout can never be missed.
    assign w_to_hit = (r_to_cnt >= (TO_MAX - TO_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= 3'd0;
            r_grant     <= 3'd0;
            r_cmd       <= '0;
            r_vld       <= 1'b0;
            r_to_cnt    <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_cmd    <= w_sel_cmd;
                        r_grant  <= w_win;
                        r_rr_ptr <= w_next_ptr;
                        // Zero-length requests never reach the DMA port.
                        if (w_sel_cmd[70:48] == 23'd0) begin
                            r_state     <= c_RESP;
                            r_rsp_valid <= w_win_onehot;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= c_ISSUE;
                            r_vld   <= 1'b1;
                        end
                    end
                end
                c_ISSUE: begin
                    if (cmd_ack) begin
                        r_vld    <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_to_cnt != TO_MAX) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                    // dma_done takes priority over a coincident timeout.
                    if (dma_done) begin
                        r_state     <= c_RESP;
                        r_rsp_valid <= w_grant_onehot;
                        r_rsp_err   <= dma_err;
                    end else if (w_to_hit) begin
                        r_state     <= c_RESP;
                        r_rsp_valid <= w_grant_onehot;
                        r_rsp_err   <= 1'b1;
                    end
                end
                c_RESP: begin
                    r_rsp_valid <= '0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_accept ? w_win_onehot : '0;
    assign cmd_tdata = {r_vld, r_cmd};
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != c_IDLE);
    assign grant_id  = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_sata_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sata_cmd_sched
// Description : Self-checking bench for sata_cmd_sched. A table of per-cycle
//               input/expected-output records covers single requests and
//               round-robin ordering; hand sequences cover zero length,
//               timeout, done-vs-timeout priority and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sata_cmd_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [287:0] req_cmd;
    logic [72:0]  cmd_tdata;
    logic         cmd_ack;
    logic         dma_done;
    logic         dma_err;
    logic [3:0]   rsp_valid;
    logic         rsp_err;
    logic         busy;
    logic [2:0]   grant_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sata_cmd_sched #(
        .NUM_REQ (4),
        .TO_W    (24),
        .TO_MAX  (24'd16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .cmd_tdata (cmd_tdata),
        .cmd_ack   (cmd_ack),
        .dma_done  (dma_done),
        .dma_err   (dma_err),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    typedef struct {
        logic [3:0]  rv;
        logic        ack;
        logic        done;
        logic        err;
        logic        rstn;
        logic [13:0] exp;
        logic        chk_cmd;
        logic [72:0] exp_cmd;
    } vec_t;

    vec_t tbl[$];

    // Requester i: RW=i[0], len=8*i+8, addr=0x1000*i
    function automatic logic [71:0] cmd_of(input int i);
        return {1'(i % 2), 23'(8 * i + 8), 48'(i * 4096)};
    endfunction

    // Packed view {req_ready, vld, rsp_valid, rsp_err, busy, grant_id}
    function automatic logic [13:0] ob(input logic [3:0] rdy, input logic vld,
                                       input logic [3:0] rv, input logic re,
                                       input logic b, input logic [2:0] g);
        return {rdy, vld, rv, re, b, g};
    endfunction

    function automatic vec_t mk(input logic [3:0] rv, input logic ack,
                                input logic done, input logic err,
                                input logic rstn, input logic [13:0] exp,
                                input logic chk_cmd, input logic [72:0] exp_cmd);
        vec_t v;
        v.rv = rv; v.ack = ack; v.done = done; v.err = err; v.rstn = rstn;
        v.exp = exp; v.chk_cmd = chk_cmd; v.exp_cmd = exp_cmd;
        return v;
    endfunction

    // One full transaction: accept, issue+ack, done, response.
    task automatic push_txn(input logic [3:0] rv, input int w, input int prev,
                            input logic e);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        tbl.push_back(mk(rv, 0, 0, 0, 1, ob(oh, 0, 4'b0, 0, 0, 3'(prev)), 0, '0));
        tbl.push_back(mk(rv, 1, 0, 0, 1, ob(4'b0, 1, 4'b0, 0, 1, 3'(w)), 1,
                         {1'b1, cmd_of(w)}));
        tbl.push_back(mk(rv, 0, 1, e, 1, ob(4'b0, 0, 4'b0, 0, 1, 3'(w)), 0, '0));
        tbl.push_back(mk(rv, 0, 0, 0, 1, ob(4'b0, 0, oh, e, 1, 3'(w)), 0, '0));
    endtask

    task automatic check(input string name, input logic [72:0] act,
                         input logic [72:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic ack, input logic done,
                         input logic err, input logic rstn);
        @(negedge clk);
        req_valid = rv;
        cmd_ack   = ack;
        dma_done  = done;
        dma_err   = err;
        rst_n     = rstn;
        #1;
    endtask

    function automatic logic [13:0] observe();
        return {req_ready, cmd_tdata[72], rsp_valid, rsp_err, busy, grant_id};
    endfunction

    task automatic step(input string name, input logic [3:0] rv, input logic ack,
                        input logic done, input logic err, input logic rstn,
                        input logic [13:0] exp);
        drive(rv, ack, done, err, rstn);
        check(name, 73'(observe()), 73'(exp));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0;
        cmd_ack   = 1'b0;
        dma_done  = 1'b0;
        dma_err   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_cmd[72*i +: 72] = cmd_of(i);
        end
        repeat (3) @(posedge clk);

        // Reset state, then single request on requester 1.
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd0), 0, '0));
        tbl.push_back(mk(4'b0010, 0, 0, 0, 1, ob(4'b0010, 0, 4'b0000, 0, 0, 3'd0), 0, '0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, ob(4'b0000, 1, 4'b0000, 0, 1, 3'd1), 1,
                         73'h1_80_0010_0000_0000_1000));
        tbl.push_back(mk(4'b0000, 1, 0, 0, 1, ob(4'b0000, 1, 4'b0000, 0, 1, 3'd1), 1,
                         73'h1_80_0010_0000_0000_1000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 1, 3'd1), 0, '0));
        tbl.push_back(mk(4'b0000, 0, 1, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 1, 3'd1), 0, '0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0010, 0, 1, 3'd1), 0, '0));
        // ack/done while idle are ignored
        tbl.push_back(mk(4'b0000, 1, 1, 1, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd1), 0, '0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd1), 0, '0));
        // reset cycle: no ready even with all valid; pointer and grant cleared
        tbl.push_back(mk(4'b1111, 0, 0, 0, 0, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd1), 0, '0));
        // Round-robin with all valid: 0,1,2,3,0
        push_txn(4'b1111, 0, 0, 1'b0);
        push_txn(4'b1111, 1, 0, 1'b0);
        push_txn(4'b1111, 2, 1, 1'b1);
        push_txn(4'b1111, 3, 2, 1'b0);
        push_txn(4'b1111, 0, 3, 1'b0);
        // Move pointer to 3, then wrap: 0 then 1, pointer ends at 2
        push_txn(4'b0100, 2, 0, 1'b0);
        push_txn(4'b0011, 0, 2, 1'b0);
        push_txn(4'b0011, 1, 0, 1'b1);
        push_txn(4'b1111, 2, 1, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].ack, tbl[i].done, tbl[i].err, tbl[i].rstn);
            check($sformatf("row%0d", i), 73'(observe()), 73'(tbl[i].exp));
            if (tbl[i].chk_cmd) begin
                check($sformatf("row%0d_cmd", i), cmd_tdata, tbl[i].exp_cmd);
            end
        end

        // Zero length on requester 2 (pointer is 3)
        req_cmd[72*2 +: 72] = {1'b0, 23'd0, 48'hABC};
        step("zl_accept", 4'b0100, 0, 0, 0, 1, ob(4'b0100, 0, 4'b0000, 0, 0, 3'd2));
        step("zl_rsp",    4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0100, 1, 1, 3'd2));
        step("zl_idle",   4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd2));
        req_cmd[72*2 +: 72] = cmd_of(2);

        // Timeout after exactly 16 WAIT_DONE cycles
        step("to_accept", 4'b0001, 0, 0, 0, 1, ob(4'b0001, 0, 4'b0000, 0, 0, 3'd2));
        step("to_ack",    4'b0000, 1, 0, 0, 1, ob(4'b0000, 1, 4'b0000, 0, 1, 3'd0));
        for (int j = 1; j <= 16; j++) begin
            step($sformatf("to_wait%0d", j), 4'b0000, 0, 0, 0, 1,
                 ob(4'b0000, 0, 4'b0000, 0, 1, 3'd0));
        end
        step("to_rsp",  4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0001, 1, 1, 3'd0));
        step("to_idle", 4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd0));

        // dma_done on the timeout cycle wins
        step("sc_accept", 4'b0001, 0, 0, 0, 1, ob(4'b0001, 0, 4'b0000, 0, 0, 3'd0));
        step("sc_ack",    4'b0000, 1, 0, 0, 1, ob(4'b0000, 1, 4'b0000, 0, 1, 3'd0));
        for (int j = 1; j <= 16; j++) begin
            step($sformatf("sc_wait%0d", j), 4'b0000, 0, (j == 16), 0, 1,
                 ob(4'b0000, 0, 4'b0000, 0, 1, 3'd0));
        end
        step("sc_rsp",  4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0001, 0, 1, 3'd0));
        step("sc_idle", 4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd0));

        // Synchronous reset during WAIT_DONE
        step("rs_accept", 4'b0010, 0, 0, 0, 1, ob(4'b0010, 0, 4'b0000, 0, 0, 3'd0));
        step("rs_ack",    4'b0000, 1, 0, 0, 1, ob(4'b0000, 1, 4'b0000, 0, 1, 3'd1));
        step("rs_wait1",  4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 1, 3'd1));
        step("rs_wait2",  4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 1, 3'd1));
        step("rs_assert", 4'b0000, 0, 0, 0, 0, ob(4'b0000, 0, 4'b0000, 0, 1, 3'd1));
        step("rs_after",  4'b0000, 0, 0, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd0));
        check("rs_cmd_zero", cmd_tdata, 73'd0);
        step("rs_late_done", 4'b0000, 0, 1, 0, 1, ob(4'b0000, 0, 4'b0000, 0, 0, 3'd0));
        for (int j = 0; j < 3; j++) begin
            step($sformatf("rs_quiet%0d", j), 4'b0000, 0, 0, 0, 1,
                 ob(4'b0000, 0, 4'b0000, 0, 0, 3'd0));
        end
        step("rs_ptr0", 4'b1111, 0, 0, 0, 1, ob(4'b0001, 0, 4'b0000, 0, 0, 3'd0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
